// File: rtl/alu_bist_ctrl_if.sv
// alu_bist_ctrl_if: connection between the ALU self-test controller and the ALU.
//   alu_a, alu_b   operands to the ALU (32 bits each)
//   alu_aluc       6-bit ALU opcode
//   alu_r          ALU result (32 bits)
//   alu_zero       ALU zero flag
// master: the BIST side (drives the operands and opcode, reads the result).
// slave:  the ALU side.
interface alu_bist_ctrl_if;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [5:0]  alu_aluc;
   logic [31:0] alu_r;
   logic        alu_zero;

   modport master (
      output alu_a,
      output alu_b,
      output alu_aluc,
      input  alu_r,
      input  alu_zero
   );

   modport slave (
      input  alu_a,
      input  alu_b,
      input  alu_aluc,
      output alu_r,
      output alu_zero
   );
endinterface

// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: self-test initiator for a 32-bit MIPS-style ALU.
// A 17-entry opcode table is walked with fixed operands. For each vector the controller
// drives the operands and opcode, waits SETTLE_CYCLES, then compares alu_r and alu_zero
// with the built-in expected values.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        one-cycle run request (accepted in IDLE or DONE only)
//   alu          alu_bist_ctrl_if.master: alu_a/alu_b/alu_aluc out, alu_r/alu_zero in
//   busy         run in progress
//   done         run finished; held until the next accepted start or reset
//   pass         valid with done: no mismatching vectors
//   err_cnt      number of failing vectors (saturates at 31)
//   fail_idx     index of the first failing vector (0 if none)
//   fail_r       alu_r captured at the first failure (0 if none)
// Build option: define ALU_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
// The expected table holds only for the default OPERAND_A/OPERAND_B values.
module alu_bist_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [31:0] OPERAND_A     = 32'h0000001c,
   parameter logic [31:0] OPERAND_B     = 32'h00000021
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   alu_bist_ctrl_if.master       alu,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [4:0]            err_cnt,
   output logic [4:0]            fail_idx,
   output logic [31:0]           fail_r
);

   localparam logic [4:0] LastIdx    = 5'd16;
   localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StDrive, StWait, StCheck, StDone} state_e;

   state_e      state;
   logic [4:0]  idx;
   logic [3:0]  wait_cnt;

   logic [5:0]  tbl_aluc;
   logic [31:0] tbl_exp;
   logic        mismatch;
   logic        finish;
   logic [4:0]  err_inc;

   // Vector table: opcode and expected result for OPERAND_A = 0x1c, OPERAND_B = 0x21.
   always_comb begin
      tbl_aluc = 6'b000000;
      tbl_exp  = 32'h0;
      unique case (idx)
         5'd0:    begin tbl_aluc = 6'b100000; tbl_exp = 32'h0000003d; end
         5'd1:    begin tbl_aluc = 6'b100001; tbl_exp = 32'h0000003d; end
         5'd2:    begin tbl_aluc = 6'b100010; tbl_exp = 32'hfffffffb; end
         5'd3:    begin tbl_aluc = 6'b100011; tbl_exp = 32'hfffffffb; end
         5'd4:    begin tbl_aluc = 6'b100100; tbl_exp = 32'h00000000; end
         5'd5:    begin tbl_aluc = 6'b100101; tbl_exp = 32'h0000003d; end
         5'd6:    begin tbl_aluc = 6'b100110; tbl_exp = 32'h0000003d; end
         5'd7:    begin tbl_aluc = 6'b100111; tbl_exp = 32'hffffffc2; end
         5'd8:    begin tbl_aluc = 6'b101010; tbl_exp = 32'h00000001; end
         5'd9:    begin tbl_aluc = 6'b101011; tbl_exp = 32'h00000001; end
         5'd10:   begin tbl_aluc = 6'b000000; tbl_exp = 32'h10000000; end
         5'd11:   begin tbl_aluc = 6'b000010; tbl_exp = 32'h00000000; end
         5'd12:   begin tbl_aluc = 6'b000011; tbl_exp = 32'h00000000; end
         5'd13:   begin tbl_aluc = 6'b000100; tbl_exp = 32'h10000000; end
         5'd14:   begin tbl_aluc = 6'b000110; tbl_exp = 32'h00000000; end
         5'd15:   begin tbl_aluc = 6'b000111; tbl_exp = 32'h00000000; end
         5'd16:   begin tbl_aluc = 6'b001111; tbl_exp = 32'h001c0000; end
         default: begin tbl_aluc = 6'b000000; tbl_exp = 32'h0;        end
      endcase
   end

   assign mismatch = (alu.alu_r != tbl_exp) || (alu.alu_zero != (tbl_exp == 32'h0));
   assign err_inc  = (err_cnt == 5'd31) ? err_cnt : err_cnt + 5'd1;

`ifdef ALU_BIST_STOP_ON_FAIL_EN
   assign finish = mismatch || (idx == LastIdx);
`else
   assign finish = (idx == LastIdx);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= StIdle;
         idx          <= 5'd0;
         wait_cnt     <= 4'd0;
         alu.alu_a    <= 32'h0;
         alu.alu_b    <= 32'h0;
         alu.alu_aluc <= 6'h0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         err_cnt      <= 5'd0;
         fail_idx     <= 5'd0;
         fail_r       <= 32'h0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state    <= StDrive;
                  idx      <= 5'd0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  pass     <= 1'b0;
                  err_cnt  <= 5'd0;
                  fail_idx <= 5'd0;
                  fail_r   <= 32'h0;
               end
            end
            StDrive: begin
               alu.alu_a    <= OPERAND_A;
               alu.alu_b    <= OPERAND_B;
               alu.alu_aluc <= tbl_aluc;
               wait_cnt     <= 4'd0;
               state        <= StWait;
            end
            StWait: begin
               if (wait_cnt == SettleLast) begin
                  state <= StCheck;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            StCheck: begin
               if (mismatch) begin
                  err_cnt <= err_inc;
                  // err_cnt saturates and never returns to zero, so zero marks the first failure
                  if (err_cnt == 5'd0) begin
                     fail_idx <= idx;
                     fail_r   <= alu.alu_r;
                  end
               end
               if (finish) begin
                  state <= StDone;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !mismatch && (err_cnt == 5'd0);
               end else begin
                  idx   <= idx + 5'd1;
                  state <= StDrive;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
